// File: rtl/main_fsm.sv
// Multicycle control FSM for the ARM-subset core: sequences Fetch/Decode/Execute/Memory/Writeback
// and decodes datapath selects plus raw write enables for Conditional_Logic.
module main_fsm (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       Mem_Ready,
  output logic       Mem_Req,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NoWrite,
  output logic [1:0] FlagW
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb,
    StMemWrite, StExecR, StExecI, StAluWb, StBranch
  } state_e;

  state_e state_q, state_d;
  logic   nowrite_q;

  logic [3:0] cmd;
  logic       s_bit;
  logic       in_exec;
  logic [1:0] alu_ctl;
  logic [1:0] alu_flagw;
  logic       alu_nowrite;

  assign cmd     = Funct[4:1];
  assign s_bit   = Funct[0];
  assign in_exec = (state_q == StExecR) || (state_q == StExecI);

  // Unrecognised commands fall back to ADD with no flag update.
  always_comb begin
    alu_ctl     = 2'b00;
    alu_flagw   = 2'b00;
    alu_nowrite = 1'b0;
    case (cmd)
      4'b0100: begin alu_ctl = 2'b00; alu_flagw = {s_bit, s_bit}; end
      4'b0010: begin alu_ctl = 2'b01; alu_flagw = {s_bit, s_bit}; end
      4'b0000: begin alu_ctl = 2'b10; alu_flagw = {s_bit, 1'b0}; end
      4'b1100: begin alu_ctl = 2'b11; alu_flagw = {s_bit, 1'b0}; end
      4'b1010: begin alu_ctl = 2'b01; alu_flagw = 2'b11; alu_nowrite = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (Mem_Ready) state_d = StDecode;
      StDecode: begin
        case (Op)
          2'b01:   state_d = StMemAdr;
          2'b00:   state_d = Funct[5] ? StExecI : StExecR;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = Funct[0] ? StMemRead : StMemWrite;
      StMemRead:  if (Mem_Ready) state_d = StMemWb;
      StMemWrite: if (Mem_Ready) state_d = StFetch;
      StExecR,
      StExecI:    state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= StFetch;
      nowrite_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_exec) nowrite_q <= alu_nowrite;
    end
  end

  always_comb begin
    Mem_Req    = 1'b0;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    PCS        = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    NoWrite    = 1'b0;
    FlagW      = 2'b00;
    case (state_q)
      StFetch: begin
        Mem_Req   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = Mem_Ready;
        NextPC    = Mem_Ready;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StMemAdr:  ALUSrcB = 2'b01;
      StMemRead: begin
        Mem_Req = 1'b1;
        AdrSrc  = 1'b1;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        PCS       = (Rd == 4'hF);
      end
      StMemWrite: begin
        Mem_Req = 1'b1;
        AdrSrc  = 1'b1;
        MemW    = 1'b1;
      end
      StExecR, StExecI: begin
        ALUSrcB    = (state_q == StExecI) ? 2'b01 : 2'b00;
        ALUControl = alu_ctl;
        FlagW      = alu_flagw;
        NoWrite    = alu_nowrite;
      end
      StAluWb: begin
        RegW = ~nowrite_q;
        PCS  = (Rd == 4'hF) & ~nowrite_q;
      end
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCS       = 1'b1;
      end
      default: ;
    endcase
    // Reset suppresses every enable, including the Mem_Ready-qualified ones.
    if (!Reset_n) begin
      Mem_Req = 1'b0;
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      PCS     = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      FlagW   = 2'b00;
    end
  end

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: per-instruction expected-output queue built from the instruction class,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_main_fsm;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [3:0] Rd = 4'b0;
  logic       Mem_Ready = 1'b1;
  logic       Mem_Req, IRWrite, NextPC, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
  logic       PCS, RegW, MemW, NoWrite;

  main_fsm dut (
    .Clk(Clk), .Reset_n(Reset_n), .Op(Op), .Funct(Funct), .Rd(Rd), .Mem_Ready(Mem_Ready),
    .Mem_Req(Mem_Req), .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl), .PCS(PCS),
    .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .FlagW(FlagW)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       mreq, irw, npc, adr, srca;
    logic [1:0] srcb, res, aluc;
    logic       pcs, regw, memw, nw;
    logic [1:0] flagw;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic mem;    // step waits for Mem_Ready
    logic fetch;  // IRWrite/NextPC follow Mem_Ready
  } step_t;

  step_t      q[$];
  obs_t       o;
  logic       known = 1'b0;
  int         ccnt = 0;
  int         last_lat = 0;
  int         errors = 0;
  int         checks = 0;
  logic [1:0] cur_op = 2'b11;
  logic [5:0] cur_funct = 6'b0;
  logic [3:0] cur_rd = 4'b0;
  logic [3:0] cmds [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic alu_ref(input logic [5:0] fn, output logic [1:0] ac, output logic [1:0] fw,
                         output logic nw);
    logic s;
    s  = fn[0];
    nw = 1'b0;
    case (fn[4:1])
      4'b0100: begin ac = 2'd0; fw = {s, s}; end
      4'b0010: begin ac = 2'd1; fw = {s, s}; end
      4'b0000: begin ac = 2'd2; fw = {s, 1'b0}; end
      4'b1100: begin ac = 2'd3; fw = {s, 1'b0}; end
      4'b1010: begin ac = 2'd1; fw = 2'b11; nw = 1'b1; end
      default: begin ac = 2'd0; fw = 2'b00; end
    endcase
  endtask

  task automatic build(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
    step_t      s;
    logic [1:0] ac, fw;
    logic       nw;
    s = '0; s.o.mreq = 1; s.o.srca = 1; s.o.srcb = 2; s.o.res = 2; s.mem = 1; s.fetch = 1;
    q.push_back(s);
    s = '0; s.o.srca = 1; s.o.srcb = 2; s.o.res = 2;
    q.push_back(s);
    case (op)
      2'd0: begin
        alu_ref(fn, ac, fw, nw);
        s = '0; s.o.srcb = fn[5] ? 2'd1 : 2'd0; s.o.aluc = ac; s.o.flagw = fw; s.o.nw = nw;
        q.push_back(s);
        s = '0; s.o.regw = !nw; s.o.pcs = (rd == 4'hF) && !nw;
        q.push_back(s);
      end
      2'd1: begin
        s = '0; s.o.srcb = 2'd1;
        q.push_back(s);
        if (fn[0]) begin
          s = '0; s.o.mreq = 1; s.o.adr = 1; s.mem = 1;
          q.push_back(s);
          s = '0; s.o.res = 2'd1; s.o.regw = 1; s.o.pcs = (rd == 4'hF);
          q.push_back(s);
        end else begin
          s = '0; s.o.mreq = 1; s.o.adr = 1; s.o.memw = 1; s.mem = 1;
          q.push_back(s);
        end
      end
      2'd2: begin
        s = '0; s.o.srcb = 2'd1; s.o.res = 2'd2; s.o.pcs = 1;
        q.push_back(s);
      end
      default: ;
    endcase
  endtask

  // One clock: drive at negedge, compare 1 time unit later, advance the model at posedge.
  task automatic cyc(input logic rst, input logic mr);
    obs_t e;
    @(negedge Clk);
    if (known && q.size() == 0) build(cur_op, cur_funct, cur_rd);
    Reset_n = rst; Mem_Ready = mr; Op = cur_op; Funct = cur_funct; Rd = cur_rd;
    #1;
    o = '{mreq: Mem_Req, irw: IRWrite, npc: NextPC, adr: AdrSrc, srca: ALUSrcA,
          srcb: ALUSrcB, res: ResultSrc, aluc: ALUControl, pcs: PCS, regw: RegW,
          memw: MemW, nw: NoWrite, flagw: FlagW};
    if (known) begin
      e = q[0].o;
      e.irw = q[0].fetch & mr & rst;
      e.npc = e.irw;
      if (!rst) begin
        e.mreq = 0; e.regw = 0; e.memw = 0; e.pcs = 0; e.flagw = 2'b00;
      end
      chk("outputs", 32'(o), 32'(e));
    end
    @(posedge Clk);
    if (!rst) begin
      known = 1'b1;
      q.delete();
      ccnt = 0;
    end else if (known) begin
      ccnt++;
      if (!(q[0].mem && !mr)) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          last_lat = ccnt;
          ccnt = 0;
        end
      end
    end
  endtask

  function automatic logic [7:0] enables(input obs_t x);
    return {x.mreq, x.irw, x.npc, x.regw, x.memw, x.pcs, x.flagw};
  endfunction

  initial begin
    // Reset held two cycles
    cyc(1'b0, 1'b1);
    chk("reset_en0", 32'(enables(o)), 32'h0);
    cur_op = 2'b00; cur_funct = 6'b001000; cur_rd = 4'd1;
    cyc(1'b0, 1'b1);
    chk("reset_en1", 32'(enables(o)), 32'h0);

    // ADD R1, register form
    cyc(1'b1, 1'b1);
    chk("fetch_irw_npc", 32'({o.irw, o.npc, o.mreq, o.adr}), 32'b1110);
    cyc(1'b1, 1'b1);
    chk("decode_srcs", 32'({o.srca, o.srcb, o.mreq}), 32'b1100);
    cyc(1'b1, 1'b1);
    chk("add_exec", 32'({o.srcb, o.aluc, o.flagw, o.nw}), 32'b0);
    cyc(1'b1, 1'b1);
    chk("add_wb", 32'({o.regw, o.pcs, o.res}), 32'b1000);
    chk("add_lat", 32'(last_lat), 32'd4);

    // CMP immediate, Rd=15 so a stray PCS would show
    cur_op = 2'b00; cur_funct = 6'b110101; cur_rd = 4'hF;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("cmp_exec", 32'({o.srcb, o.aluc, o.flagw, o.nw}), 32'b01_01_11_1);
    cyc(1'b1, 1'b1);
    chk("cmp_wb", 32'({o.regw, o.pcs}), 32'b00);

    // LDR R15 with three wait cycles in MEMREAD
    cur_op = 2'b01; cur_funct = 6'b011001; cur_rd = 4'hF;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, (i == 3));
      chk("ldr_memread", 32'({o.mreq, o.adr, o.memw}), 32'b110);
    end
    cyc(1'b1, 1'b1);
    chk("ldr_memwb", 32'({o.res, o.regw, o.pcs}), 32'b01_1_1);
    chk("ldr_lat", 32'(last_lat), 32'd8);

    // STR interrupted by reset during the write wait
    cur_op = 2'b01; cur_funct = 6'b011000; cur_rd = 4'd2;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("str_memw0", 32'(o.memw), 32'd1);
    cyc(1'b1, 1'b0);
    chk("str_memw1", 32'(o.memw), 32'd1);
    cyc(1'b0, 1'b0);
    chk("str_reset_en", 32'(enables(o)), 32'h0);
    cyc(1'b1, 1'b1);
    chk("str_refetch", 32'({o.mreq, o.adr, o.irw}), 32'b101);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("str_lat", 32'(last_lat), 32'd4);

    // B
    cur_op = 2'b10; cur_funct = 6'b0; cur_rd = 4'd0;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("branch", 32'({o.pcs, o.srcb, o.srca, o.regw}), 32'b1_01_0_0);
    chk("b_lat", 32'(last_lat), 32'd3);

    // Op=11 behaves as a NOP
    cur_op = 2'b11; cur_funct = 6'b111111; cur_rd = 4'hF;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("nop_decode_en", 32'(enables(o)), 32'h0);
    chk("nop_lat", 32'(last_lat), 32'd2);

    // Randomized traffic with memory waits and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0) begin
        cur_op    = 2'($urandom_range(0, 3));
        cur_funct = 6'($urandom);
        if ($urandom_range(0, 1) == 1) cur_funct[4:1] = cmds[$urandom_range(0, 4)];
        cur_rd    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      end
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
